local_ni_rx: RTL and testbench

Receive-side network interface at a router's LOCAL output port; the sink end of the router_if valid/ready link.
- Accepts flits from the router LOCAL output and checks that each flit's destination matches this node's coordinates.
- Buffers matching flits in a small FIFO and presents them to the local core with valid/ready.
- Keeps saturating receive and drop counters plus a sticky misroute flag; one instance per mesh node.

---
 rtl/global_params_pkg.sv | 17 +
 rtl/rx_fifo.sv | 69 ++++++
 rtl/local_ni_rx.sv | 96 +++++++++
 tb/tb_local_ni_rx.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/global_params_pkg.sv
// Mesh-wide parameters and the flit payload carried on router_if links.
package global_params;

    localparam int unsigned DATA_WIDTH = 512;
    localparam int unsigned MESH_SIDE  = 4;
    localparam int unsigned COORD_W    = $clog2(MESH_SIDE);

    // One flit as presented by a router output port.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [COORD_W-1:0]    dest_x;
        logic [COORD_W-1:0]    dest_y;
        logic                  s_delta_x;
        logic                  s_delta_y;
    } flit_t;

endpackage

// File: rtl/rx_fifo.sv
// Receive buffer: circular FIFO with occupancy counter and registered
// not_full / not_empty flags (no combinational path from push/pop).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, wr_data     write request and payload (ignored when full)
//   pop               read request (ignored when empty)
//   rd_data           head-of-FIFO payload
//   not_full          registered: room for at least one more entry
//   not_empty         registered: at least one entry buffered
module rx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             not_full,
    output logic             not_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;
    logic             push_ok;
    logic             pop_ok;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign push_ok  = push & not_full;
    assign pop_ok   = pop & not_empty;
    assign occ_next = occ + OCC_W'(push_ok) - OCC_W'(pop_ok);
    assign rd_data  = mem[rd_ptr];

    // Payload storage carries no reset; validity is tracked by occ.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            not_full  <= 1'b0;
            not_empty <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
            occ       <= occ_next;
            not_full  <= (occ_next != OCC_W'(DEPTH));
            not_empty <= (occ_next != '0);
        end
    end

endmodule

// File: rtl/local_ni_rx.sv
// Receive network interface at a router LOCAL output port. Checks each
// accepted flit's destination against this node, buffers matches for the
// local core and counts/flags misrouted flits.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_data/dest/sdx/sdy      flit from router LOCAL output
//   in_valid, in_ready        router handshake (in_ready registered)
//   core_data/valid/ready     delivery to local core
//   clr_stats                 synchronous clear of counters and flag
//   rx_count, drop_count      saturating accepted / misrouted counts
//   err_misroute              sticky misroute indication
module local_ni_rx
    import global_params::*;
#(
    parameter int unsigned X_COORD    = 1,
    parameter int unsigned Y_COORD    = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [COORD_W-1:0]    in_dest_x,
    input  logic [COORD_W-1:0]    in_dest_y,
    input  logic                  in_sdx,
    input  logic                  in_sdy,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] core_data,
    output logic                  core_valid,
    input  logic                  core_ready,
    input  logic                  clr_stats,
    output logic [CNT_W-1:0]      rx_count,
    output logic [CNT_W-1:0]      drop_count,
    output logic                  err_misroute
);

    flit_t in_flit;
    logic  accept;
    logic  dest_match;
    logic  rx_evt;
    logic  drop_evt;
    logic  unused_sdelta;

    assign in_flit = '{data:      in_data,
                       dest_x:    in_dest_x,
                       dest_y:    in_dest_y,
                       s_delta_x: in_sdx,
                       s_delta_y: in_sdy};

    // Sign-of-delta bits only steer routing upstream; nothing to do here.
    assign unused_sdelta = in_flit.s_delta_x ^ in_flit.s_delta_y;

    assign accept     = in_valid & in_ready;
    assign dest_match = (in_flit.dest_x == COORD_W'(X_COORD)) &&
                        (in_flit.dest_y == COORD_W'(Y_COORD));
    assign rx_evt     = accept & dest_match;
    assign drop_evt   = accept & ~dest_match;

    // Misrouted flits are consumed from the link but never buffered.
    rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (rx_evt),
        .wr_data   (in_flit.data),
        .pop       (core_ready),
        .rd_data   (core_data),
        .not_full  (in_ready),
        .not_empty (core_valid)
    );

    // Statistics; a same-cycle clear wins over the coincident event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_count     <= '0;
            drop_count   <= '0;
            err_misroute <= 1'b0;
        end else if (clr_stats) begin
            rx_count     <= '0;
            drop_count   <= '0;
            err_misroute <= 1'b0;
        end else begin
            if (rx_evt && (rx_count != '1)) begin
                rx_count <= rx_count + CNT_W'(1);
            end
            if (drop_evt) begin
                if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
                err_misroute <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_local_ni_rx.sv
// Directed bench for local_ni_rx at node (2,1); a second instance with a
// 4-bit counter width exercises saturation without long streams.
module tb_local_ni_rx;
    import global_params::*;

    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned CW = COORD_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_dest_x;
    logic [CW-1:0] in_dest_y;
    logic          in_sdx;
    logic          in_sdy;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] core_data;
    logic          core_valid;
    logic          core_ready;
    logic          clr_stats;
    logic [15:0]   rx_count;
    logic [15:0]   drop_count;
    logic          err_misroute;

    logic          s_in_ready;
    logic [DW-1:0] s_core_data;
    logic          s_core_valid;
    logic [3:0]    s_rx_count;
    logic [3:0]    s_drop_count;
    logic          s_err_misroute;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    local_ni_rx #(.X_COORD(2), .Y_COORD(1), .FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest_x(in_dest_x),
        .in_dest_y(in_dest_y), .in_sdx(in_sdx), .in_sdy(in_sdy),
        .in_valid(in_valid), .in_ready(in_ready), .core_data(core_data),
        .core_valid(core_valid), .core_ready(core_ready),
        .clr_stats(clr_stats), .rx_count(rx_count), .drop_count(drop_count),
        .err_misroute(err_misroute)
    );

    local_ni_rx #(.X_COORD(2), .Y_COORD(1), .FIFO_DEPTH(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_dest_x(in_dest_x),
        .in_dest_y(in_dest_y), .in_sdx(in_sdx), .in_sdy(in_sdy),
        .in_valid(in_valid), .in_ready(s_in_ready), .core_data(s_core_data),
        .core_valid(s_core_valid), .core_ready(core_ready),
        .clr_stats(1'b0), .rx_count(s_rx_count), .drop_count(s_drop_count),
        .err_misroute(s_err_misroute)
    );

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one flit and hold it until the edge that accepts it.
    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] dx, input logic [CW-1:0] dy);
        bit acc = 1'b0;
        in_data   = d;
        in_dest_x = dx;
        in_dest_y = dy;
        in_sdx    = 1'b1;
        in_sdy    = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 50 && !acc; c++) begin
            acc = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic pulse_clr();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    logic [DW-1:0] got_q [5];
    int            n_got;
    logic [DW-1:0] pat5;

    // Collect up to 5 heads while core_ready is high.
    task automatic consume5();
        n_got = 0;
        core_ready = 1'b1;
        for (int c = 0; c < 30 && n_got < 5; c++) begin
            if (core_valid) begin
                got_q[n_got] = core_data;
                n_got++;
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; in_data = '0; in_dest_x = '0; in_dest_y = '0;
        in_sdx = 1'b0; in_sdy = 1'b0; in_valid = 1'b0;
        core_ready = 1'b0; clr_stats = 1'b0;
        pat5 = {128{4'h5}};

        // 1: reset values, in_ready rises one edge after release
        repeat (3) tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_core_valid", core_valid, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_err", err_misroute, 0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", in_ready, 0);
        tick();
        chk("rel_in_ready", in_ready, 1);

        // 2: single matching flit, one-cycle latency
        core_ready = 1'b1;
        send(pat5, 2, 1);
        chk("t2_core_valid", core_valid, 1);
        chk("t2_core_data", core_data, pat5);
        chk("t2_rx_count", rx_count, 1);
        tick();
        chk("t2_core_valid_after_pop", core_valid, 0);

        // 3: fill to depth, backpressure, strict ordering
        pulse_clr();
        core_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(DW'(i), 2, 1);
        chk("t3_in_ready_full", in_ready, 0);
        chk("t3_head", core_data, DW'(1));
        in_data = DW'(5); in_dest_x = 2; in_dest_y = 1; in_valid = 1'b1;
        tick(); tick();
        chk("t3_in_ready_held", in_ready, 0);
        chk("t3_head_stable", core_data, DW'(1));
        chk("t3_valid_stable", core_valid, 1);
        fork
            send(DW'(5), 2, 1);
            consume5();
        join
        chk("t3_n_out", DW'(n_got), DW'(5));
        for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), got_q[i], DW'(i + 1));
        chk("t3_empty", core_valid, 0);
        chk("t3_rx_count", rx_count, 5);

        // 4: misrouted flit dropped, clear
        send(DW'(8'hAA), 1, 1);
        chk("t4_in_ready", in_ready, 1);
        chk("t4_core_valid", core_valid, 0);
        chk("t4_drop_count", drop_count, 1);
        chk("t4_err", err_misroute, 1);
        chk("t4_rx_unchanged", rx_count, 5);
        pulse_clr();
        chk("t4_drop_clr", drop_count, 0);
        chk("t4_err_clr", err_misroute, 0);

        // 5: clear beats a coincident accept; flit still delivered
        for (int i = 0; i < 7; i++) send(DW'(16'h700 + i), 2, 1);
        chk("t5_rx7", rx_count, 7);
        clr_stats = 1'b1;
        send(DW'(16'hBEEF), 2, 1);
        clr_stats = 1'b0;
        chk("t5_rx_clr", rx_count, 0);
        chk("t5_delivered_valid", core_valid, 1);
        chk("t5_delivered_data", core_data, DW'(16'hBEEF));
        tick();

        // 6: asynchronous reset mid-cycle discards buffered flits
        core_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(DW'(16'hC00 + i), 2, 1);
        chk("t6_buffered", core_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_valid", core_valid, 0);
        chk("t6_async_ready", in_ready, 0);
        chk("t6_async_rx", rx_count, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_rel_ready", in_ready, 1);
        chk("t6_rel_empty", core_valid, 0);
        core_ready = 1'b1;
        send(DW'(16'hD00D), 2, 1);
        chk("t6_new_valid", core_valid, 1);
        chk("t6_new_data", core_data, DW'(16'hD00D));

        // Saturation: narrow counter sticks at all-ones
        for (int i = 0; i < 14; i++) send(DW'(100 + i), 2, 1);
        chk("sat_rx_at_max", s_rx_count, 4'hF);
        chk("sat_main_rx15", rx_count, 15);
        send(DW'(200), 2, 1);
        chk("sat_rx_held", s_rx_count, 4'hF);
        chk("sat_main_rx16", rx_count, 16);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
